// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// Optional MemReady handshake present only when MEM_WAIT_EN is defined.
interface multicycle_controller_if;
    // instruction fields and flags from the datapath
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       Zero;
`ifdef MEM_WAIT_EN
    logic       MemReady;
`endif
    // control outputs to the datapath
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       InstrDone;
    logic       Illegal;

    modport master (
        input  op, funct3, funct7_5, Zero,
`ifdef MEM_WAIT_EN
        input  MemReady,
`endif
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, InstrDone, Illegal
    );

    modport slave (
        output op, funct3, funct7_5, Zero,
`ifdef MEM_WAIT_EN
        output MemReady,
`endif
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, InstrDone, Illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RV32I-subset datapath (shared ALU,
// unified memory). Optional macro MEM_WAIT_EN adds a MemReady stall input
// that holds FETCH, MEMREAD and MEMWRITE until memory responds.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALUOp encoding between the state decode and the ALU decoder
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    state_t     state, state_next;
    logic [1:0] alu_op;
    logic       mem_ready;

`ifdef MEM_WAIT_EN
    assign mem_ready = bus.MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    // state register, reset returns to FETCH
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    // next-state sequencing
    always_comb begin
        state_next = state;
        case (state)
            FETCH:    if (mem_ready) state_next = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECR;
                    OP_I:         state_next = EXECI;
                    OP_BR:        state_next = BRANCH;
                    OP_JAL:       state_next = JAL;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready) state_next = MEMWB;
            MEMWB:    state_next = FETCH;
            MEMWRITE: if (mem_ready) state_next = FETCH;
            EXECR:    state_next = ALUWB;
            EXECI:    state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BRANCH:   state_next = FETCH;
            JAL:      state_next = ALUWB;
            default:  state_next = FETCH;
        endcase
    end

    // state-decoded controls; reset masks every write enable and pulse
    always_comb begin
        bus.PCWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.InstrDone = 1'b0;
        bus.Illegal   = 1'b0;
        alu_op        = ALUOP_ADD;
        case (state)
            FETCH: begin
                bus.IRWrite   = mem_ready;
                bus.PCWrite   = mem_ready;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                if (!(bus.op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL})) begin
                    bus.Illegal   = 1'b1;
                    bus.InstrDone = 1'b1;
                end
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            MEMREAD:  bus.AdrSrc = 1'b1;
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
                bus.InstrDone = 1'b1;
            end
            MEMWRITE: begin
                bus.AdrSrc    = 1'b1;
                bus.MemWrite  = mem_ready;
                bus.InstrDone = mem_ready;
            end
            EXECR: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = ALUOP_FUNC;
            end
            EXECI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                alu_op      = ALUOP_FUNC;
            end
            ALUWB: begin
                bus.RegWrite  = 1'b1;
                bus.InstrDone = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA   = 2'b10;
                alu_op        = ALUOP_SUB;
                bus.InstrDone = 1'b1;
                case (bus.funct3)
                    3'b000:  bus.PCWrite = bus.Zero;
                    3'b001:  bus.PCWrite = ~bus.Zero;
                    default: bus.PCWrite = 1'b0;
                endcase
            end
            JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            bus.PCWrite   = 1'b0;
            bus.IRWrite   = 1'b0;
            bus.RegWrite  = 1'b0;
            bus.MemWrite  = 1'b0;
            bus.InstrDone = 1'b0;
            bus.Illegal   = 1'b0;
        end
    end

    // ALU operation decode from ALUOp and funct fields
    always_comb begin
        bus.ALUControl = 3'b000;
        case (alu_op)
            ALUOP_SUB:  bus.ALUControl = 3'b001;
            ALUOP_FUNC: begin
                case (bus.funct3)
                    3'b000:  bus.ALUControl = (bus.op[5] & bus.funct7_5) ? 3'b001 : 3'b000;
                    3'b010:  bus.ALUControl = 3'b101;
                    3'b110:  bus.ALUControl = 3'b011;
                    3'b111:  bus.ALUControl = 3'b010;
                    default: bus.ALUControl = 3'b000;
                endcase
            end
            default:    bus.ALUControl = 3'b000;
        endcase
    end

    // immediate format follows the opcode in every state
    always_comb begin
        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BR:   bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control
// vectors are queued as stimulus is applied and checked at the falling edge.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [17:0] sb_q[$];

    multicycle_controller_if bus();

    multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,
    //  ALUControl,ImmSrc,InstrDone,Illegal}
    function automatic logic [17:0] pk(logic pcw, logic adr, logic mw, logic irw,
                                       logic rw, logic [1:0] rs, logic [1:0] sa,
                                       logic [1:0] sb, logic [2:0] ac,
                                       logic [1:0] imm, logic done, logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, imm, done, ill};
    endfunction

    function automatic logic [17:0] obs();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                bus.ImmSrc, bus.InstrDone, bus.Illegal};
    endfunction

    // queue one cycle's expectation, compare at negedge, move past next posedge
    task automatic step(input string tag, input logic pcw, input logic adr,
                        input logic mw, input logic irw, input logic rw,
                        input logic [1:0] rs, input logic [1:0] sa,
                        input logic [1:0] sb, input logic [2:0] ac,
                        input logic [1:0] imm, input logic done, input logic ill);
        logic [17:0] e, o;
        sb_q.push_back(pk(pcw, adr, mw, irw, rw, rs, sa, sb, ac, imm, done, ill));
        @(negedge clk);
        o = obs();
        e = sb_q.pop_front();
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic fetch(input string tag, input logic [1:0] imm, input logic rdy);
        step(tag, rdy, 0, 0, rdy, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
    endtask

    task automatic decode(input string tag, input logic [1:0] imm);
        step(tag, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0);
    endtask

    task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        bus.op = o; bus.funct3 = f3; bus.funct7_5 = f7; bus.Zero = z;
    endtask

    // R/I ALU instruction: 4 cycles with given operand B select and ALU code
    task automatic alu_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic [1:0] sb, input logic [2:0] ac);
        set_ir(o, f3, f7, 1'b0);
        fetch({tag, "_fetch"}, 2'b00, 1'b1);
        decode({tag, "_decode"}, 2'b00);
        step({tag, "_exec"}, 0, 0, 0, 0, 0, 2'b00, 2'b10, sb, ac, 2'b00, 0, 0);
        step({tag, "_wb"}, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0);
    endtask

    task automatic branch_instr(input string tag, input logic [2:0] f3, input logic z, input logic pcw);
        set_ir(7'b1100011, f3, 1'b0, z);
        fetch({tag, "_fetch"}, 2'b10, 1'b1);
        decode({tag, "_decode"}, 2'b10);
        step({tag, "_branch"}, pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1, 0);
    endtask

    initial begin
        logic [5:0] en;
        set_ir(7'b0000011, 3'b010, 1'b0, 1'b0);
`ifdef MEM_WAIT_EN
        bus.MemReady = 1'b1;
`endif
        // reset held for two cycles: enables must stay low
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            en = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.InstrDone, bus.Illegal};
            total++;
            assert (en === 6'b0) else begin
                bad++;
                $error("FAIL reset_enables observed=%b expected=%b", en, 6'b0);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // lw: 5 cycles
        fetch("lw_fetch", 2'b00, 1'b1);
        decode("lw_decode", 2'b00);
        step("lw_memadr", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0);
        step("lw_memread", 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
        step("lw_memwb", 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0);

        // R / I ALU decode
        alu_instr("r_sub",  7'b0110011, 3'b000, 1'b1, 2'b00, 3'b001);
        alu_instr("r_add",  7'b0110011, 3'b000, 1'b0, 2'b00, 3'b000);
        alu_instr("r_or",   7'b0110011, 3'b110, 1'b0, 2'b00, 3'b011);
        alu_instr("r_xor",  7'b0110011, 3'b100, 1'b0, 2'b00, 3'b000);
        alu_instr("i_addi", 7'b0010011, 3'b000, 1'b1, 2'b01, 3'b000);
        alu_instr("i_slti", 7'b0010011, 3'b010, 1'b0, 2'b01, 3'b101);
        alu_instr("i_andi", 7'b0010011, 3'b111, 1'b0, 2'b01, 3'b010);

        // branches
        branch_instr("beq_z1", 3'b000, 1'b1, 1'b1);
        branch_instr("beq_z0", 3'b000, 1'b0, 1'b0);
        branch_instr("bne_z0", 3'b001, 1'b0, 1'b1);
        branch_instr("bne_z1", 3'b001, 1'b1, 1'b0);
        branch_instr("blt_z1", 3'b100, 1'b1, 1'b0);

        // jal: FETCH, DECODE, JAL, ALUWB
        set_ir(7'b1101111, 3'b000, 1'b0, 1'b0);
        fetch("jal_fetch", 2'b11, 1'b1);
        decode("jal_decode", 2'b11);
        step("jal_jal", 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0);
        step("jal_wb", 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 1, 0);

        // sw: 4 cycles
        set_ir(7'b0100011, 3'b010, 1'b0, 1'b0);
        fetch("sw_fetch", 2'b01, 1'b1);
        decode("sw_decode", 2'b01);
        step("sw_memadr", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0);
        step("sw_memwrite", 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1, 0);

        // illegal opcode: 2 cycles, then FETCH again
        set_ir(7'b1111111, 3'b000, 1'b0, 1'b0);
        fetch("ill_fetch", 2'b00, 1'b1);
        step("ill_decode", 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 1, 1);

        // reset asserted in MEMWRITE suppresses the write
        set_ir(7'b0100011, 3'b010, 1'b0, 1'b0);
        fetch("ill_next_fetch", 2'b01, 1'b1);
        decode("rsw_decode", 2'b01);
        step("rsw_memadr", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0);
        rst = 1'b1;
        step("rsw_memwrite_rst", 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0);
        rst = 1'b0;
        fetch("rsw_after_fetch", 2'b01, 1'b1);
        decode("rsw_after_decode", 2'b01);
        step("rsw_after_memadr", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0);
        step("rsw_after_memwrite", 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1, 0);

`ifdef MEM_WAIT_EN
        // stalled FETCH, then sw with MemReady low for 3 cycles in MEMWRITE
        bus.MemReady = 1'b0;
        fetch("wait_fetch_hold", 2'b01, 1'b0);
        bus.MemReady = 1'b1;
        fetch("wait_fetch", 2'b01, 1'b1);
        decode("wait_decode", 2'b01);
        step("wait_memadr", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0);
        bus.MemReady = 1'b0;
        for (int i = 0; i < 3; i++)
            step("wait_memwrite_hold", 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0);
        bus.MemReady = 1'b1;
        step("wait_memwrite", 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1, 0);
        fetch("wait_after_fetch", 2'b01, 1'b1);
`else
        fetch("final_fetch", 2'b01, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
